floor_req_encoder: RTL
======================

Name: floor_req_encoder

Overview:
- Collects one-hot floor-call button inputs, holds them as pending requests, and encodes one request at a time into a binary floor code for the elevator controller.
- It is the encoding counterpart to the 4-to-8 floor decoder: the decoder turns a 4-bit floor code into one-hot lines, and this block turns one-hot button lines back into a 4-bit code.
- Handoff to the controller uses a valid/ready handshake.
- Fair round-robin arbitration ensures no floor is starved.

Parameters:
- NUM_FLOORS, 8, number of one-hot request lines (2..16).
- CODE_W, 4, width of the binary floor code. Must satisfy 2^CODE_W >= NUM_FLOORS.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk.
- btn  input  NUM_FLOORS  raw, asynchronous button levels; bit i is the call for floor i.
- flush  input  1  synchronous clear of all pending requests and of any offer in progress.
- out_ready  input  1  controller accepts the offered code.
- out_valid  output  1  floor_code is valid and held stable.
- floor_code  output  CODE_W  binary index of the offered floor; upper bits are zero.
- pending  output  NUM_FLOORS  registered pending-request mask, used for the call LEDs.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sync stages s1, s2, s3 = 0; pending = 0; floor_code = 0; out_valid = 0.
  - Round-robin pointer last = NUM_FLOORS-1, so the first search starts at floor 0.
  - FSM = IDLE.
  - Reset asserted mid-offer drops out_valid immediately, with no handshake.
- Input conditioning:
  - Per bit, three flops: s1 <= btn, s2 <= s1, s3 <= s2.
  - rise = s2 & ~s3.
  - A button held high registers exactly one request; re-arming requires release for at least 1 cycle after it reaches s3.
- Pending update, each cycle: pending <= (pending & ~clr) | rise.
  - clr is the one-hot of floor_code when out_valid & out_ready.
  - A rise on the same bit in the same cycle as clr wins: the bit stays set.
  - flush overrides everything: pending <= 0.
- Latency: btn high before edge k gives s1 at k, s2 at k+1, pending bit at k+2. With the FSM in IDLE, SELECT follows at k+3 and out_valid=1 after edge k+4.
- FSM:
  - IDLE: out_valid=0. Go to SELECT if |pending, else stay.
  - SELECT (1 cycle):
    - Search pending circularly starting at last+1 and wrapping at NUM_FLOORS-1 to 0.
    - Register the first set index into floor_code.
    - Go to OFFER. Pending is nonzero here by construction, since flush returns to IDLE.
  - OFFER: out_valid=1.
    - floor_code is held constant while out_ready=0.
    - On out_valid & out_ready: clear that pending bit, last <= floor_code, go to IDLE.
    - Next offer is no earlier than 2 cycles later, so out_valid deasserts for at least 1 cycle between offers.
- flush:
  - Active in any state: next cycle pending=0, out_valid=0, FSM=IDLE. last is unchanged.
  - flush and out_ready in the same cycle: flush wins; the handshake is ignored and last is unchanged.
- New requests arriving during OFFER do not change floor_code; they are considered at the next SELECT.
- Boundary cases:
  - NUM_FLOORS not a power of two: the search wraps at NUM_FLOORS-1. btn bits at or above NUM_FLOORS do not exist.
  - All floors pending: floors are served in strict rotation, and each floor waits at most NUM_FLOORS-1 grants.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
1. Reset release, then btn=8'h04 held 20 cycles with out_ready=1:
   - pending=8'h04 at k+2; out_valid=1, floor_code=2 at k+4, for exactly 1 cycle.
   - pending returns to 0.
   - No second offer while btn stays high; a second offer appears only after a release and a new press.
2. Pulse btn=8'hFF for 1 cycle, out_ready=1 constantly:
   - Codes 0,1,2,...,7 in order.
   - out_valid low for at least 1 cycle between each.
   - pending ends at 0.
3. Rotation after a grant. Serve floor 5 (last=5), then press floors 1 and 6 together:
   - Floor 6 is offered first, then floor 1.
4. Backpressure and re-press collision. Floor 3 offered, out_ready=0 for 10 cycles:
   - out_valid and floor_code=3 stay stable.
   - A press of floor 0 mid-wait does not change the code.
   - Then out_ready=1 in the same cycle that a fresh rise on floor 3 arrives: pending[3] remains 1, and floor 0 is offered next.
5. flush during OFFER (floor 4, pending=8'h91) with out_ready=1 in the same cycle:
   - Next cycle out_valid=0, pending=0, and last is unchanged.
6. Assert rst_n=0 asynchronously mid-cycle during OFFER:
   - out_valid and pending go to 0 before the next clk edge.
   - After release, the first offer of all-pending requests starts at floor 0.

Source files
------------

// File: rtl/floor_req_encoder.sv
`default_nettype none
// ============================================================================
// Module   : floor_req_encoder
// Brief    : Latches one-hot floor-call buttons as pending requests and offers
//            them one at a time as a binary floor code, round-robin fair.
// Revision : 1.0  initial release
// ============================================================================
module floor_req_encoder #(
    parameter int NUM_FLOORS = 8,
    parameter int CODE_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic                  flush,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [CODE_W-1:0]     floor_code,
    output logic [NUM_FLOORS-1:0] pending
);

    // Pointer starts on the top floor so the very first search begins at floor 0.
    localparam logic [CODE_W-1:0] c_last_init = CODE_W'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_OFFER  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [NUM_FLOORS-1:0]   r_s1;
    logic [NUM_FLOORS-1:0]   r_s2;
    logic [NUM_FLOORS-1:0]   r_s3;
    logic [NUM_FLOORS-1:0]   r_pending;
    logic [CODE_W-1:0]       r_code;
    logic [CODE_W-1:0]       r_last;
    logic                    r_valid;

    logic [NUM_FLOORS-1:0]   w_rise;
    logic [NUM_FLOORS-1:0]   w_clr;
    logic                    w_accept;
    logic                    w_load_code;
    logic [CODE_W-1:0]       w_sel;
    int                      w_start;
    int                      w_dist;
    int                      w_best;

    assign w_rise      = r_s2 & ~r_s3;
    assign w_load_code = (r_state == ST_SELECT) && !flush;

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_clr
        assign w_clr[g] = w_accept && (r_code == CODE_W'(g));
    end

    // Circular search: the set bit nearest after the last grant wins.
    always_comb begin
        w_start = (int'(r_last) >= NUM_FLOORS - 1) ? 0 : int'(r_last) + 1;
        w_best  = NUM_FLOORS;
        w_dist  = 0;
        w_sel   = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (r_pending[i]) begin
                w_dist = (i >= w_start) ? (i - w_start) : (i + NUM_FLOORS - w_start);
                if (w_dist < w_best) begin
                    w_best = w_dist;
                    w_sel  = CODE_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!flush && (|r_pending)) begin
                    w_state_next = ST_SELECT;
                end
            end
            ST_SELECT: begin
                w_state_next = flush ? ST_IDLE : ST_OFFER;
            end
            ST_OFFER: begin
                if (flush) begin
                    w_state_next = ST_IDLE;
                end else if (out_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_s3      <= '0;
            r_pending <= '0;
            r_code    <= '0;
            r_last    <= c_last_init;
            r_valid   <= 1'b0;
        end else begin
            r_s1 <= btn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            // A fresh rise re-arms a bit even as its old request is cleared.
            if (flush) begin
                r_pending <= '0;
            end else begin
                r_pending <= (r_pending & ~w_clr) | w_rise;
            end
            if (w_load_code) begin
                r_code <= w_sel;
            end
            if (w_accept) begin
                r_last <= r_code;
            end
            r_valid <= (w_state_next == ST_OFFER);
        end
    end

    assign out_valid  = r_valid;
    assign floor_code = r_code;
    assign pending    = r_pending;

endmodule
`default_nettype wire
